// File: rtl/mulmod_serial_pkg.sv
// Shared constants and operator-responder handshake states for the curve25519 datapath.
package mulmod_serial_pkg;

    localparam int MULMOD_N = 255;

    // 2^255 - 19
    localparam logic [MULMOD_N-1:0] P25519 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    // 2*d mod P25519, the Edwards-curve point-addition constant
    localparam logic [MULMOD_N-1:0] K25519 =
        255'h2406d9dc_56dffce7_198e80f2_eef3d130_00e0149a_8283b156_ebd69b94_26b2f159;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } op_state_t;

endpackage

// File: rtl/mulmod_step.sv
// One MSB-first double-and-add step: next = (2*acc + ybit*xr) mod M, with acc, xr < M.
// Purely combinational; both reductions are single conditional subtracts.
module mulmod_step
    import mulmod_serial_pkg::*;
#(
    parameter int              N = MULMOD_N,
    parameter logic [N-1:0]    M = P25519
) (
    input  logic [N-1:0] acc,
    input  logic [N-1:0] xr,
    input  logic         ybit,
    output logic [N-1:0] acc_nxt
);

    localparam logic [N:0] MX = {1'b0, M};

    logic [N:0]   dbl;
    logic [N-1:0] dbl_red;
    logic [N:0]   sum;
    logic [N-1:0] sum_red;

    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= MX) ? N'(dbl - MX) : dbl[N-1:0];
        sum     = {1'b0, dbl_red} + {1'b0, xr};
        sum_red = (sum >= MX) ? N'(sum - MX) : sum[N-1:0];
        acc_nxt = ybit ? sum_red : dbl_red;
    end

endmodule

// File: rtl/mulmod_serial.sv
// Bit-serial Z = X*Y mod P25519; result 255 cycles after the req_ready pulse (128 with MULMOD_SERIAL_RADIX4_EN).
// Result and res_valid hold in DONE until res_ready; req_valid is ignored outside IDLE.
module mulmod_serial
    import mulmod_serial_pkg::*;
#(
    parameter int           N = MULMOD_N,
    parameter logic [N-1:0] M = P25519
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] Z,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam int CW = 8;

`ifdef MULMOD_SERIAL_RADIX4_EN
    localparam logic [CW-1:0] CNT_INIT = CW'((N + 1) / 2 - 1);
    logic [N:0]   yr;
    logic [N-1:0] acc_mid;
`else
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    logic [N-1:0] yr;
`endif

    op_state_t    state;
    op_state_t    state_nxt;
    logic [N-1:0] xr;
    logic [N-1:0] acc;
    logic [N-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic         accept;
    logic         finish;
    logic         res_take;

`ifdef MULMOD_SERIAL_RADIX4_EN
    // Two chained steps consume Y bits {2*cnt+1, 2*cnt}, high bit first.
    mulmod_step #(.N(N), .M(M)) u_step_hi (
        .acc     (acc),
        .xr      (xr),
        .ybit    (yr[{cnt[6:0], 1'b1}]),
        .acc_nxt (acc_mid)
    );

    mulmod_step #(.N(N), .M(M)) u_step_lo (
        .acc     (acc_mid),
        .xr      (xr),
        .ybit    (yr[{cnt[6:0], 1'b0}]),
        .acc_nxt (acc_nxt)
    );
`else
    mulmod_step #(.N(N), .M(M)) u_step (
        .acc     (acc),
        .xr      (xr),
        .ybit    (yr[cnt]),
        .acc_nxt (acc_nxt)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state == IDLE) && req_valid;
        finish   = (state == RUN) && (cnt == '0);
        res_take = (state == DONE) && res_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b0;
            req_busy  <= 1'b0;
            res_valid <= 1'b0;
            Z         <= '0;
            acc       <= '0;
            cnt       <= '0;
            xr        <= '0;
            yr        <= '0;
        end else begin
            req_ready <= accept;
            if (accept) begin
                // X < 2^255 < 2M, so one subtract fully reduces it.
                xr       <= (X >= M) ? X - M : X;
`ifdef MULMOD_SERIAL_RADIX4_EN
                yr       <= {1'b0, Y};
`else
                yr       <= Y;
`endif
                acc      <= '0;
                cnt      <= CNT_INIT;
                req_busy <= 1'b1;
            end
            if (state == RUN) begin
                acc <= acc_nxt;
                if (finish) begin
                    Z         <= acc_nxt;
                    res_valid <= 1'b1;
                    req_busy  <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (res_take) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
